// File: rtl/ysyx_25010008_pkg.sv
// +--------------------------------------------------------------------+
// | ysyx_25010008_pkg: shared AXI widths and read-arbiter encodings     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package ysyx_25010008_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GNT_IFU = 2'd1,
    ST_GNT_LSU = 2'd2
  } arb_state_t;

  typedef enum logic {
    MST_IFU = 1'b0,
    MST_LSU = 1'b1
  } master_t;

endpackage

`default_nettype wire

// File: rtl/ysyx_25010008_arbiter.sv
// +--------------------------------------------------------------------+
// | ysyx_25010008_arbiter: IFU/LSU read arbiter with LSU write bypass   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module ysyx_25010008_arbiter
  import ysyx_25010008_pkg::*;
#(
  parameter int ROUND_ROBIN = 0
) (
  input  logic              clk,
  input  logic              rst,
  // IFU read channels
  input  logic [ADDR_W-1:0] ifu_araddr,
  input  logic              ifu_arvalid,
  output logic              ifu_arready,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic              ifu_rresp,
  output logic              ifu_rvalid,
  input  logic              ifu_rready,
  // LSU read channels
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic              lsu_arvalid,
  output logic              lsu_arready,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              lsu_rresp,
  output logic              lsu_rvalid,
  input  logic              lsu_rready,
  // LSU write channels
  input  logic [ADDR_W-1:0] lsu_awaddr,
  input  logic              lsu_awvalid,
  output logic              lsu_awready,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [STRB_W-1:0] lsu_wstrb,
  input  logic              lsu_wvalid,
  output logic              lsu_wready,
  output logic              lsu_bresp,
  output logic              lsu_bvalid,
  input  logic              lsu_bready,
  // Memory read channels
  output logic [ADDR_W-1:0] mem_araddr,
  output logic              mem_arvalid,
  input  logic              mem_arready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rresp,
  input  logic              mem_rvalid,
  output logic              mem_rready,
  // Memory write channels
  output logic [ADDR_W-1:0] mem_awaddr,
  output logic              mem_awvalid,
  input  logic              mem_awready,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  output logic              mem_wvalid,
  input  logic              mem_wready,
  input  logic              mem_bresp,
  input  logic              mem_bvalid,
  output logic              mem_bready
);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  logic       r_ar_done;
  master_t    r_last_grant;

  logic       w_own_ifu;
  logic       w_own_lsu;
  logic       w_ar_hs;
  logic       w_r_hs;

  assign w_own_ifu = (r_state == ST_GNT_IFU);
  assign w_own_lsu = (r_state == ST_GNT_LSU);
  assign w_ar_hs   = mem_arvalid && mem_arready;
  assign w_r_hs    = mem_rvalid && mem_rready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_ar_done    <= 1'b0;
      r_last_grant <= MST_IFU;
    end else begin
      r_state <= w_state_nxt;
      if (w_r_hs) begin
        r_ar_done <= 1'b0;
      end else if (w_ar_hs) begin
        r_ar_done <= 1'b1;
      end
      if (r_state == ST_IDLE && w_state_nxt == ST_GNT_LSU) begin
        r_last_grant <= MST_LSU;
      end else if (r_state == ST_IDLE && w_state_nxt == ST_GNT_IFU) begin
        r_last_grant <= MST_IFU;
      end
    end
  end

  // Grants are only made from IDLE, which guarantees one idle cycle between reads.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (ifu_arvalid && lsu_arvalid) begin
          if ((ROUND_ROBIN != 0) && (r_last_grant == MST_LSU)) begin
            w_state_nxt = ST_GNT_IFU;
          end else begin
            w_state_nxt = ST_GNT_LSU;
          end
        end else if (lsu_arvalid) begin
          w_state_nxt = ST_GNT_LSU;
        end else if (ifu_arvalid) begin
          w_state_nxt = ST_GNT_IFU;
        end
      end
      ST_GNT_IFU, ST_GNT_LSU: begin
        if (w_r_hs) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Once the address has been accepted, AR is masked so it is never issued twice.
  always_comb begin
    mem_araddr  = '0;
    mem_arvalid = 1'b0;
    mem_rready  = 1'b0;
    ifu_arready = 1'b0;
    ifu_rdata   = '0;
    ifu_rresp   = 1'b0;
    ifu_rvalid  = 1'b0;
    lsu_arready = 1'b0;
    lsu_rdata   = '0;
    lsu_rresp   = 1'b0;
    lsu_rvalid  = 1'b0;
    if (w_own_ifu) begin
      mem_araddr  = ifu_araddr;
      mem_arvalid = ifu_arvalid && !r_ar_done;
      ifu_arready = mem_arready && !r_ar_done;
      mem_rready  = ifu_rready;
      ifu_rdata   = mem_rdata;
      ifu_rresp   = mem_rresp;
      ifu_rvalid  = mem_rvalid;
    end else if (w_own_lsu) begin
      mem_araddr  = lsu_araddr;
      mem_arvalid = lsu_arvalid && !r_ar_done;
      lsu_arready = mem_arready && !r_ar_done;
      mem_rready  = lsu_rready;
      lsu_rdata   = mem_rdata;
      lsu_rresp   = mem_rresp;
      lsu_rvalid  = mem_rvalid;
    end
  end

  // Write path bypasses arbitration entirely and may overlap any read.
  assign mem_awaddr  = lsu_awaddr;
  assign mem_awvalid = lsu_awvalid;
  assign lsu_awready = mem_awready;
  assign mem_wdata   = lsu_wdata;
  assign mem_wstrb   = lsu_wstrb;
  assign mem_wvalid  = lsu_wvalid;
  assign lsu_wready  = mem_wready;
  assign lsu_bresp   = mem_bresp;
  assign lsu_bvalid  = mem_bvalid;
  assign mem_bready  = lsu_bready;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_25010008_arbiter.sv
// +--------------------------------------------------------------------+
// | tb_ysyx_25010008_arbiter: directed bench, instance 0 fixed priority |
// | and instance 1 round robin, each backed by a small SRAM slave       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_ysyx_25010008_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  // Master-side stimulus, shared by both instances
  logic [31:0] ifu_araddr, lsu_araddr, lsu_awaddr, lsu_wdata, lsu_wstrb;
  logic        ifu_arvalid, ifu_rready, lsu_arvalid, lsu_rready;
  logic        lsu_awvalid, lsu_wvalid, lsu_bready;

  // Per-instance observations
  logic [1:0]  ifu_arready, ifu_rresp, ifu_rvalid, lsu_arready, lsu_rresp, lsu_rvalid;
  logic [1:0]  lsu_awready, lsu_wready, lsu_bresp, lsu_bvalid;
  logic [31:0] ifu_rdata [2];
  logic [31:0] lsu_rdata [2];

  // Memory side per instance
  logic [31:0] m_araddr [2];
  logic [31:0] m_awaddr [2];
  logic [31:0] m_wdata  [2];
  logic [31:0] m_wstrb  [2];
  logic [31:0] s_rdata  [2];
  logic [1:0]  m_arvalid, m_arready, m_rresp, m_rready, m_awvalid, m_awready;
  logic [1:0]  m_wvalid, m_wready, m_bresp, m_bready, s_rvalid, s_bvalid;

  for (genvar gk = 0; gk < 2; gk++) begin : g_dut
    ysyx_25010008_arbiter #(.ROUND_ROBIN(gk)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .ifu_araddr  (ifu_araddr),
      .ifu_arvalid (ifu_arvalid),
      .ifu_arready (ifu_arready[gk]),
      .ifu_rdata   (ifu_rdata[gk]),
      .ifu_rresp   (ifu_rresp[gk]),
      .ifu_rvalid  (ifu_rvalid[gk]),
      .ifu_rready  (ifu_rready),
      .lsu_araddr  (lsu_araddr),
      .lsu_arvalid (lsu_arvalid),
      .lsu_arready (lsu_arready[gk]),
      .lsu_rdata   (lsu_rdata[gk]),
      .lsu_rresp   (lsu_rresp[gk]),
      .lsu_rvalid  (lsu_rvalid[gk]),
      .lsu_rready  (lsu_rready),
      .lsu_awaddr  (lsu_awaddr),
      .lsu_awvalid (lsu_awvalid),
      .lsu_awready (lsu_awready[gk]),
      .lsu_wdata   (lsu_wdata),
      .lsu_wstrb   (lsu_wstrb),
      .lsu_wvalid  (lsu_wvalid),
      .lsu_wready  (lsu_wready[gk]),
      .lsu_bresp   (lsu_bresp[gk]),
      .lsu_bvalid  (lsu_bvalid[gk]),
      .lsu_bready  (lsu_bready),
      .mem_araddr  (m_araddr[gk]),
      .mem_arvalid (m_arvalid[gk]),
      .mem_arready (m_arready[gk]),
      .mem_rdata   (s_rdata[gk]),
      .mem_rresp   (m_rresp[gk]),
      .mem_rvalid  (s_rvalid[gk]),
      .mem_rready  (m_rready[gk]),
      .mem_awaddr  (m_awaddr[gk]),
      .mem_awvalid (m_awvalid[gk]),
      .mem_awready (m_awready[gk]),
      .mem_wdata   (m_wdata[gk]),
      .mem_wstrb   (m_wstrb[gk]),
      .mem_wvalid  (m_wvalid[gk]),
      .mem_wready  (m_wready[gk]),
      .mem_bresp   (m_bresp[gk]),
      .mem_bvalid  (s_bvalid[gk]),
      .mem_bready  (m_bready[gk])
    );
  end

  // SRAM slave: one read or write in flight each, data one cycle after the handshake
  logic [31:0] sram [2][16];
  assign m_arready = ~s_rvalid;
  assign m_awready = ~s_bvalid;
  assign m_wready  = ~s_bvalid;
  assign m_rresp   = 2'b00;
  assign m_bresp   = 2'b00;

  function automatic logic [3:0] idx(input logic [31:0] a);
    return {a[12], a[4:2]};
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        s_rvalid[k]   <= 1'b0;
        s_bvalid[k]   <= 1'b0;
        sram[k][0]    <= 32'h0000_0413;
        sram[k][4]    <= 32'h0000_0000;
        sram[k][8]    <= 32'h1234_5678;
      end else begin
        if (s_rvalid[k] && m_rready[k]) begin
          s_rvalid[k] <= 1'b0;
        end else if (m_arvalid[k] && m_arready[k]) begin
          s_rvalid[k] <= 1'b1;
          s_rdata[k]  <= sram[k][idx(m_araddr[k])];
        end
        if (s_bvalid[k] && m_bready[k]) begin
          s_bvalid[k] <= 1'b0;
        end else if (m_awvalid[k] && m_wvalid[k] && m_awready[k]) begin
          s_bvalid[k] <= 1'b1;
          for (int b = 0; b < 4; b++) begin
            if (m_wstrb[k][b]) sram[k][idx(m_awaddr[k])][8*b +: 8] <= m_wdata[k][8*b +: 8];
          end
        end
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  logic [3:0] order;
  int         d1_cnt, d0_lsu, d0_ifu;

  initial begin
    ifu_araddr = '0; ifu_arvalid = 0; ifu_rready = 0;
    lsu_araddr = '0; lsu_arvalid = 0; lsu_rready = 0;
    lsu_awaddr = '0; lsu_awvalid = 0; lsu_wdata = '0; lsu_wstrb = '0;
    lsu_wvalid = 0; lsu_bready = 0;
    order = '0; d1_cnt = 0; d0_lsu = 0; d0_ifu = 0;

    // Reset state; write path still passes through
    repeat (2) @(negedge clk);
    lsu_wdata = 32'hcafe_f00d;
    #1;
    chk("rst_mem_arvalid", m_arvalid[0], 0);
    chk("rst_mem_rready", m_rready[0], 0);
    chk("rst_ifu_arready", ifu_arready[0], 0);
    chk("rst_lsu_rvalid", lsu_rvalid[0], 0);
    chk("rst_wdata_pass", m_wdata[0], 32'hcafe_f00d);
    @(negedge clk);
    rst = 0; lsu_wdata = '0;

    // Lone IFU read
    ifu_araddr = 32'h8000_0000; ifu_arvalid = 1; ifu_rready = 1;
    #1 chk("t1_idle_arvalid", m_arvalid[0], 0);
    @(negedge clk);
    chk("t1_araddr", m_araddr[0], 32'h8000_0000);
    chk("t1_arvalid", m_arvalid[0], 1);
    chk("t1_ifu_arready", ifu_arready[0], 1);
    chk("t1_lsu_arready", lsu_arready[0], 0);
    @(negedge clk);
    chk("t1_ifu_rvalid", ifu_rvalid[0], 1);
    chk("t1_ifu_rdata", ifu_rdata[0], 32'h0000_0413);
    chk("t1_lsu_rvalid", lsu_rvalid[0], 0);
    chk("t1_ar_masked", m_arvalid[0], 0);
    ifu_arvalid = 0;
    @(negedge clk);
    chk("t1_done_rvalid", ifu_rvalid[0], 0);
    chk("t1_done_rready", m_rready[0], 0);

    // Simultaneous requests, fixed priority: LSU then IFU
    ifu_arvalid = 1; lsu_araddr = 32'h8000_1000; lsu_arvalid = 1; lsu_rready = 1;
    @(negedge clk);
    chk("t2_lsu_araddr", m_araddr[0], 32'h8000_1000);
    chk("t2_lsu_arready", lsu_arready[0], 1);
    chk("t2_ifu_stalled", ifu_arready[0], 0);
    @(negedge clk);
    chk("t2_lsu_rvalid", lsu_rvalid[0], 1);
    chk("t2_lsu_rdata", lsu_rdata[0], 32'h1234_5678);
    chk("t2_ifu_rvalid0", ifu_rvalid[0], 0);
    chk("t2_ifu_rdata0", ifu_rdata[0], 0);
    lsu_arvalid = 0;
    @(negedge clk);
    chk("t2_idle_gap", m_arvalid[0], 0);
    @(negedge clk);
    chk("t2_ifu_araddr", m_araddr[0], 32'h8000_0000);
    chk("t2_ifu_arready", ifu_arready[0], 1);
    @(negedge clk);
    chk("t2_ifu_rvalid", ifu_rvalid[0], 1);
    chk("t2_ifu_rdata", ifu_rdata[0], 32'h0000_0413);
    ifu_arvalid = 0;
    @(negedge clk);

    // Continuous requests from both masters for four reads
    ifu_arvalid = 1; lsu_arvalid = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (lsu_rvalid[1]) begin order = {order[2:0], 1'b1}; d1_cnt++; end
      if (ifu_rvalid[1]) begin order = {order[2:0], 1'b0}; d1_cnt++; end
      if (lsu_rvalid[0]) d0_lsu++;
      if (ifu_rvalid[0]) d0_ifu++;
    end
    ifu_arvalid = 0; lsu_arvalid = 0;
    chk("t3_rr_order", order, 4'b1010);
    chk("t3_rr_count", d1_cnt, 4);
    chk("t3_fixed_lsu", d0_lsu, 4);
    chk("t3_fixed_ifu", d0_ifu, 0);

    // LSU write overlapping an IFU read, then read back
    ifu_arvalid = 1;
    lsu_awaddr = 32'h8000_0010; lsu_awvalid = 1; lsu_wdata = 32'hdead_beef;
    lsu_wstrb = 32'h0000_000f; lsu_wvalid = 1; lsu_bready = 1;
    #1;
    chk("t4_awvalid_pass", m_awvalid[0], 1);
    chk("t4_awaddr_pass", m_awaddr[0], 32'h8000_0010);
    chk("t4_awready_pass", lsu_awready[0], 1);
    @(negedge clk);
    chk("t4_bvalid", lsu_bvalid[0], 1);
    lsu_awvalid = 0; lsu_wvalid = 0;
    @(negedge clk);
    chk("t4_ifu_rvalid", ifu_rvalid[0], 1);
    chk("t4_ifu_rdata", ifu_rdata[0], 32'h0000_0413);
    chk("t4_bvalid_done", lsu_bvalid[0], 0);
    ifu_arvalid = 0;
    @(negedge clk);
    lsu_araddr = 32'h8000_0010; lsu_arvalid = 1;
    @(negedge clk);
    @(negedge clk);
    chk("t4_readback0", lsu_rdata[0], 32'hdead_beef);
    chk("t4_readback1", lsu_rdata[1], 32'hdead_beef);
    lsu_arvalid = 0;
    @(negedge clk);

    // Owner stalls R for five cycles while LSU waits
    ifu_rready = 0; ifu_arvalid = 1;
    @(negedge clk);
    lsu_araddr = 32'h8000_1000; lsu_arvalid = 1; lsu_rready = 1;
    @(negedge clk);
    ifu_arvalid = 0;
    for (int i = 0; i < 5; i++) begin
      chk("t5_held_rvalid", ifu_rvalid[0], 1);
      chk("t5_lsu_stalled", lsu_arready[0], 0);
      chk("t5_held_rready", m_rready[0], 0);
      @(negedge clk);
    end
    ifu_rready = 1;
    @(negedge clk);
    chk("t5_release_idle", lsu_arready[0], 0);
    @(negedge clk);
    chk("t5_lsu_granted", lsu_arready[0], 1);
    chk("t5_lsu_araddr", m_araddr[0], 32'h8000_1000);
    @(negedge clk);
    chk("t5_lsu_rdata", lsu_rdata[0], 32'h1234_5678);
    lsu_arvalid = 0;
    @(negedge clk);

    // Reset between AR and R handshakes
    ifu_rready = 0; ifu_arvalid = 1;
    @(negedge clk);
    @(negedge clk);
    ifu_arvalid = 0;
    chk("t6_pre_rvalid", ifu_rvalid[0], 1);
    rst = 1; ifu_rready = 1;
    #1;
    chk("t6_rst_arvalid", m_arvalid[0], 0);
    chk("t6_rst_rready", m_rready[0], 0);
    chk("t6_rst_rvalid", ifu_rvalid[0], 0);
    chk("t6_rst_rdata", ifu_rdata[0], 0);
    @(negedge clk);
    rst = 0; ifu_arvalid = 1;
    @(negedge clk);
    chk("t6_post_arvalid", m_arvalid[0], 1);
    chk("t6_post_araddr", m_araddr[0], 32'h8000_0000);
    @(negedge clk);
    chk("t6_post_rvalid", ifu_rvalid[0], 1);
    chk("t6_post_rdata", ifu_rdata[0], 32'h0000_0413);
    ifu_arvalid = 0;
    @(negedge clk);
    chk("t6_post_idle", ifu_rvalid[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
